// File: rtl/wqe_pkt_segmenter.sv
// Pops one WQE from the TX WQE cache and splits its payload into MTU-sized
// packet descriptors, pulsing a per-WQE done strobe when the last one is taken.
module wqe_pkt_segmenter #(
    parameter int unsigned WQE_WIDTH    = 512,
    parameter int unsigned QP_PTR_WIDTH = 4,
    parameter int unsigned MTU_BYTES    = 4096,
    parameter int unsigned LEN_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wqe_cache_empty,
    output logic                    o_wqe_cache_rd,
    input  logic                    i_wqe_val,
    input  logic [WQE_WIDTH-1:0]    i_wqe,
    output logic                    o_pkt_val,
    input  logic                    i_pkt_rdy,
    output logic [QP_PTR_WIDTH-1:0] o_pkt_qpn,
    output logic [63:0]             o_pkt_wrid,
    output logic [7:0]              o_pkt_opcode,
    output logic [63:0]             o_pkt_laddr,
    output logic [63:0]             o_pkt_raddr,
    output logic [LEN_WIDTH-1:0]    o_pkt_len,
    output logic                    o_pkt_first,
    output logic                    o_pkt_last,
    output logic                    o_wqe_done,
    output logic [63:0]             o_wqe_done_wrid
);

    localparam logic [LEN_WIDTH-1:0] MTU_LEN  = LEN_WIDTH'(MTU_BYTES);
    localparam logic [63:0]          MTU_ADDR = 64'(MTU_BYTES);

    typedef enum logic [1:0] {IDLE, RD_WAIT, SEG} state_e;

    state_e                  state_q, state_d;
    logic                    rd_q, rd_d;
    logic                    pkt_val_q, pkt_val_d;
    logic [QP_PTR_WIDTH-1:0] qpn_q, qpn_d;
    logic [63:0]             wrid_q, wrid_d;
    logic [7:0]              opcode_q, opcode_d;
    logic [63:0]             laddr_q, laddr_d;
    logic [63:0]             raddr_q, raddr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic [63:0]             done_wrid_q, done_wrid_d;

    logic [LEN_WIDTH-1:0]    wqe_len_c;
    logic [LEN_WIDTH-1:0]    rem_nxt_c;
    logic                    unused_c;

    assign wqe_len_c = i_wqe[192 +: LEN_WIDTH];
    assign rem_nxt_c = rem_q - MTU_LEN;
    assign unused_c  = ^i_wqe;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        rd_d        = 1'b0;
        pkt_val_d   = pkt_val_q;
        qpn_d       = qpn_q;
        wrid_d      = wrid_q;
        opcode_d    = opcode_q;
        laddr_d     = laddr_q;
        raddr_d     = raddr_q;
        len_d       = len_q;
        rem_d       = rem_q;
        first_d     = first_q;
        last_d      = last_q;
        done_d      = 1'b0;
        done_wrid_d = done_wrid_q;
        case (state_q)
            IDLE: begin
                // A pop issued from IDLE (incl. the done cycle) moves us on next cycle
                if (rd_q) begin
                    state_d = RD_WAIT;
                end else if (!i_wqe_cache_empty) begin
                    rd_d = 1'b1;
                end
            end
            RD_WAIT: begin
                if (i_wqe_val) begin
                    qpn_d     = i_wqe[328 +: QP_PTR_WIDTH];
                    wrid_d    = i_wqe[63:0];
                    opcode_d  = i_wqe[231:224];
                    laddr_d   = i_wqe[127:64];
                    raddr_d   = i_wqe[191:128];
                    rem_d     = wqe_len_c;
                    len_d     = (wqe_len_c <= MTU_LEN) ? wqe_len_c : MTU_LEN;
                    last_d    = (wqe_len_c <= MTU_LEN);
                    first_d   = 1'b1;
                    pkt_val_d = 1'b1;
                    state_d   = SEG;
                end
            end
            SEG: begin
                if (pkt_val_q && i_pkt_rdy) begin
                    if (last_q) begin
                        pkt_val_d   = 1'b0;
                        done_d      = 1'b1;
                        done_wrid_d = wrid_q;
                        rd_d        = !i_wqe_cache_empty;
                        state_d     = IDLE;
                    end else begin
                        rem_d   = rem_nxt_c;
                        len_d   = (rem_nxt_c <= MTU_LEN) ? rem_nxt_c : MTU_LEN;
                        last_d  = (rem_nxt_c <= MTU_LEN);
                        laddr_d = laddr_q + MTU_ADDR;
                        raddr_d = raddr_q + MTU_ADDR;
                        first_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            pkt_val_q   <= 1'b0;
            qpn_q       <= '0;
            wrid_q      <= '0;
            opcode_q    <= '0;
            laddr_q     <= '0;
            raddr_q     <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            done_wrid_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            pkt_val_q   <= pkt_val_d;
            qpn_q       <= qpn_d;
            wrid_q      <= wrid_d;
            opcode_q    <= opcode_d;
            laddr_q     <= laddr_d;
            raddr_q     <= raddr_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            last_q      <= last_d;
            done_q      <= done_d;
            done_wrid_q <= done_wrid_d;
        end
    end

    assign o_wqe_cache_rd  = rd_q;
    assign o_pkt_val       = pkt_val_q;
    assign o_pkt_qpn       = qpn_q;
    assign o_pkt_wrid      = wrid_q;
    assign o_pkt_opcode    = opcode_q;
    assign o_pkt_laddr     = laddr_q;
    assign o_pkt_raddr     = raddr_q;
    assign o_pkt_len       = len_q;
    assign o_pkt_first     = first_q;
    assign o_pkt_last      = last_q;
    assign o_wqe_done      = done_q;
    assign o_wqe_done_wrid = done_wrid_q;

endmodule

// File: tb/tb_wqe_pkt_segmenter.sv
// Scoreboard bench for wqe_pkt_segmenter: a WQE cache model feeds the DUT and
// expected descriptors/done strobes are queued at push time and popped on output.
module tb_wqe_pkt_segmenter;

    localparam int unsigned MTU = 4096;

    typedef struct packed {
        logic [3:0]  qpn;
        logic [63:0] wrid;
        logic [7:0]  op;
        logic [63:0] la;
        logic [63:0] ra;
        logic [31:0] len;
        logic        first;
        logic        last;
    } desc_t;

    logic         clk, rst_n;
    logic         i_wqe_cache_empty, o_wqe_cache_rd;
    logic         i_wqe_val;
    logic [511:0] i_wqe;
    logic         o_pkt_val, i_pkt_rdy;
    logic [3:0]   o_pkt_qpn;
    logic [63:0]  o_pkt_wrid, o_pkt_laddr, o_pkt_raddr, o_wqe_done_wrid;
    logic [7:0]   o_pkt_opcode;
    logic [31:0]  o_pkt_len;
    logic         o_pkt_first, o_pkt_last, o_wqe_done;

    wqe_pkt_segmenter #(
        .WQE_WIDTH(512), .QP_PTR_WIDTH(4), .MTU_BYTES(MTU), .LEN_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wqe_cache_empty(i_wqe_cache_empty), .o_wqe_cache_rd(o_wqe_cache_rd),
        .i_wqe_val(i_wqe_val), .i_wqe(i_wqe),
        .o_pkt_val(o_pkt_val), .i_pkt_rdy(i_pkt_rdy),
        .o_pkt_qpn(o_pkt_qpn), .o_pkt_wrid(o_pkt_wrid), .o_pkt_opcode(o_pkt_opcode),
        .o_pkt_laddr(o_pkt_laddr), .o_pkt_raddr(o_pkt_raddr), .o_pkt_len(o_pkt_len),
        .o_pkt_first(o_pkt_first), .o_pkt_last(o_pkt_last),
        .o_wqe_done(o_wqe_done), .o_wqe_done_wrid(o_wqe_done_wrid)
    );

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    int           n_pops = 0;
    int           n_done = 0;
    logic [511:0] cache_q[$];
    desc_t        exp_q[$];
    logic [63:0]  done_exp_q[$];
    int           pop_cyc_q[$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Builds a WQE for the cache and queues the descriptors it must produce
    task automatic push_wqe(input logic [3:0] qpn, input logic [63:0] wrid, input logic [7:0] op,
                            input logic [63:0] la, input logic [63:0] ra, input logic [31:0] len);
        logic [511:0] w;
        logic [31:0]  rem;
        logic         first, last;
        w = '0;
        w[511:480] = $urandom;
        w[63:0]    = wrid;
        w[127:64]  = la;
        w[191:128] = ra;
        w[223:192] = len;
        w[231:224] = op;
        w[331:328] = qpn;
        cache_q.push_back(w);
        rem = len;
        first = 1'b1;
        do begin
            last = (rem <= MTU);
            exp_q.push_back({qpn, wrid, op, la, ra, last ? rem : 32'(MTU), first, last});
            rem   = rem - 32'(MTU);
            la    = la + 64'(MTU);
            ra    = ra + 64'(MTU);
            first = 1'b0;
        end while (!last);
        done_exp_q.push_back(wrid);
    endtask

    // WQE cache model: answers each pop with the head entry one cycle later
    initial begin
        logic [511:0] w;
        i_wqe_cache_empty = 1'b1;
        i_wqe_val = 1'b0;
        i_wqe = '0;
        forever begin
            @(negedge clk);
            if (rst_n && o_wqe_cache_rd) begin
                n_pops++;
                pop_cyc_q.push_back(cyc);
                chk("pop_nonempty", 256'(cache_q.size() != 0), 256'(1));
                w = (cache_q.size() != 0) ? cache_q.pop_front() : '0;
                i_wqe_cache_empty = (cache_q.size() == 0);
                @(posedge clk);
                #1;
                i_wqe_val = 1'b1;
                i_wqe = w;
                @(posedge clk);
                #1;
                i_wqe_val = 1'b0;
            end else begin
                i_wqe_cache_empty = (cache_q.size() == 0);
            end
        end
    end

    // Output monitor: descriptor scoreboard, stall stability and done strobe
    initial begin
        desc_t cur, snap, e;
        bit    stall_prev;
        stall_prev = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            cur = {o_pkt_qpn, o_pkt_wrid, o_pkt_opcode, o_pkt_laddr, o_pkt_raddr,
                   o_pkt_len, o_pkt_first, o_pkt_last};
            if (stall_prev) begin
                chk("hold_val", 256'(o_pkt_val), 256'(1));
                chk("hold_desc", 256'(cur), 256'(snap));
            end
            if (o_pkt_val && i_pkt_rdy) begin
                chk("desc_expected", 256'(exp_q.size() != 0), 256'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("qpn", 256'(o_pkt_qpn), 256'(e.qpn));
                    chk("wrid", 256'(o_pkt_wrid), 256'(e.wrid));
                    chk("opcode", 256'(o_pkt_opcode), 256'(e.op));
                    chk("laddr", 256'(o_pkt_laddr), 256'(e.la));
                    chk("raddr", 256'(o_pkt_raddr), 256'(e.ra));
                    chk("len", 256'(o_pkt_len), 256'(e.len));
                    chk("first", 256'(o_pkt_first), 256'(e.first));
                    chk("last", 256'(o_pkt_last), 256'(e.last));
                end
            end
            stall_prev = o_pkt_val && !i_pkt_rdy;
            snap = cur;
            if (o_wqe_done) begin
                n_done++;
                chk("done_expected", 256'(done_exp_q.size() != 0), 256'(1));
                if (done_exp_q.size() != 0)
                    chk("done_wrid", 256'(o_wqe_done_wrid), 256'(done_exp_q.pop_front()));
            end
        end
    end

    task automatic drain(input bit rnd_rdy);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) i_pkt_rdy = 1'($urandom_range(0, 1));
            if (exp_q.size() == 0 && done_exp_q.size() == 0 && cache_q.size() == 0) break;
        end
        i_pkt_rdy = 1'b1;
        chk("drain_left", 256'(exp_q.size() + done_exp_q.size()), 256'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, d0, ok;
        rst_n = 1'b0;
        i_pkt_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd", 256'(o_wqe_cache_rd), 256'(0));
        chk("rst_pkt_val", 256'(o_pkt_val), 256'(0));
        chk("rst_done", 256'(o_wqe_done), 256'(0));
        chk("rst_len", 256'(o_pkt_len), 256'(0));
        rst_n = 1'b1;

        // single short segment
        p0 = n_pops; d0 = n_done;
        push_wqe(4'h3, 64'hA5A5_0000_0000_0001, 8'h0A, 64'h100, 64'h2000_0000, 32'd100);
        drain(1'b0);
        chk("t1_pops", 256'(n_pops - p0), 256'(1));
        chk("t1_dones", 256'(n_done - d0), 256'(1));

        // three segments with short tail, exact multiple, zero length
        push_wqe(4'h5, 64'h1111_2222_3333_4444, 8'h08, 64'h1000, 64'h8000, 32'd10000);
        push_wqe(4'h6, 64'h0BAD_F00D_0000_0002, 8'h04, 64'h4_0000, 64'h9_0000, 32'd8192);
        push_wqe(4'h7, 64'h0000_0000_0000_0003, 8'h00, 64'h0, 64'h0, 32'd0);
        drain(1'b0);

        // back-to-back single-segment WQEs: pop spacing
        push_wqe(4'h1, 64'h10, 8'h01, 64'h40, 64'h80, 32'd64);
        push_wqe(4'h2, 64'h20, 8'h01, 64'h50, 64'h90, 32'd4096);
        drain(1'b0);
        chk("pop_gap", 256'(pop_cyc_q[$] - pop_cyc_q[$-1]), 256'(3));

        // stall in SEG with rdy low
        i_pkt_rdy = 1'b0;
        push_wqe(4'h9, 64'h5757_5757, 8'h11, 64'h7000, 64'hC000, 32'd5000);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_pkt_val) begin ok = 1; break; end
        end
        chk("stall_reach_seg", 256'(ok), 256'(1));
        p0 = n_pops; d0 = n_done;
        repeat (5) @(negedge clk);
        chk("stall_pops", 256'(n_pops - p0), 256'(0));
        chk("stall_dones", 256'(n_done - d0), 256'(0));
        @(posedge clk);
        #1;
        i_pkt_rdy = 1'b1;
        drain(1'b0);

        // remote address wraps past 2^64
        push_wqe(4'hF, 64'hFEED, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_F000, 32'd8192);
        drain(1'b0);

        // random lengths with random back-pressure
        for (int k = 0; k < 5; k++)
            push_wqe(4'($urandom), {$urandom, $urandom}, 8'($urandom),
                     {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3 * MTU + 7));
        drain(1'b1);

        // reset in the middle of segment 2 of 3
        push_wqe(4'h4, 64'hDEAD_BEEF, 8'h08, 64'h1000, 64'h2000, 32'd10000);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_pkt_val && !o_pkt_first) begin ok = 1; break; end
        end
        chk("rst_reach_seg2", 256'(ok), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pkt_val", 256'(o_pkt_val), 256'(0));
        chk("mid_rst_laddr", 256'(o_pkt_laddr), 256'(0));
        chk("mid_rst_len", 256'(o_pkt_len), 256'(0));
        chk("mid_rst_done", 256'(o_wqe_done), 256'(0));
        chk("mid_rst_rd", 256'(o_wqe_cache_rd), 256'(0));
        exp_q.delete();
        done_exp_q.delete();
        p0 = n_pops; d0 = n_done;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("empty_no_pop", 256'(n_pops - p0), 256'(0));
        chk("rst_no_done", 256'(n_done - d0), 256'(0));
        push_wqe(4'h8, 64'hC0FFEE, 8'h0A, 64'h300, 64'h600, 32'd100);
        drain(1'b0);
        chk("post_rst_pops", 256'(n_pops - p0), 256'(1));
        chk("post_rst_dones", 256'(n_done - d0), 256'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
